// File: rtl/eccop_alu_pkg.sv
// rtl/eccop_alu_pkg.sv - shared opcode layout, function codes and FSM states for the eccop ALU
package eccop_alu_pkg;

  localparam int ALU_OP_WIDTH = 6;
  localparam int FUNC_MSB     = 5;
  localparam int FUNC_LSB     = 3;
  localparam int IDX_MSB      = 2;
  localparam int IDX_LSB      = 0;

  typedef enum logic [2:0] {
    F_LD  = 3'b000,
    F_ST  = 3'b001,
    F_ADD = 3'b010,
    F_SUB = 3'b011,
    F_ADC = 3'b100,
    F_SHR = 3'b101,
    F_SHL = 3'b110,
    F_XOR = 3'b111
  } func_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EXEC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Carry/bit fed into the first word: ADC and the rotates consume C, ADD and SUB start clean.
  function automatic logic carry_init(input func_t f, input logic c);
    return (f == F_ADC || f == F_SHR || f == F_SHL) ? c : 1'b0;
  endfunction

endpackage

// File: rtl/eccop_alu_word.sv
// rtl/eccop_alu_word.sv - combinational one-word slice of the multi-precision ALU
module eccop_alu_word
  import eccop_alu_pkg::*;
#(
  parameter int P_WORD_WIDTH = 32
) (
  input  func_t                   func,
  input  logic [P_WORD_WIDTH-1:0] a,
  input  logic [P_WORD_WIDTH-1:0] b,
  input  logic                    cin,
  output logic [P_WORD_WIDTH-1:0] y,
  output logic                    cout
);

  logic [P_WORD_WIDTH:0] sum;

  // SUB treats cin/cout as borrow: the top bit of the wrapped difference is the borrow-out.
  always_comb begin
    y    = a;
    cout = cin;
    sum  = '0;
    case (func)
      F_LD: y = b;
      F_ADD, F_ADC: begin
        sum  = {1'b0, a} + {1'b0, b} + {{P_WORD_WIDTH{1'b0}}, cin};
        y    = sum[P_WORD_WIDTH-1:0];
        cout = sum[P_WORD_WIDTH];
      end
      F_SUB: begin
        sum  = {1'b0, a} - {1'b0, b} - {{P_WORD_WIDTH{1'b0}}, cin};
        y    = sum[P_WORD_WIDTH-1:0];
        cout = sum[P_WORD_WIDTH];
      end
      F_SHR: begin
        y    = {cin, a[P_WORD_WIDTH-1:1]};
        cout = a[0];
      end
      F_SHL: begin
        y    = {a[P_WORD_WIDTH-2:0], cin};
        cout = a[P_WORD_WIDTH-1];
      end
      F_XOR: y = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/eccop_alu.sv
// rtl/eccop_alu.sv - word-serial multi-precision ALU answering the eccop MCU opcode handshake
module eccop_alu
  import eccop_alu_pkg::*;
#(
  parameter int P_OPCODE_WIDTH = 7,
  parameter int P_WORD_WIDTH   = 32,
  parameter int P_NWORDS       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [P_OPCODE_WIDTH-2:0]       alu_op_code,
  input  logic                            alu_op_req,
  output logic                            alu_op_ack,
  output logic                            alu_flags_carry,
  output logic                            alu_flags_zero,
  output logic                            alu_flags_w0,
  input  logic [3+$clog2(P_NWORDS)-1:0]   host_addr,
  input  logic [P_WORD_WIDTH-1:0]         host_wdata,
  input  logic                            host_we,
  input  logic                            host_re,
  output logic [P_WORD_WIDTH-1:0]         host_rdata,
  output logic                            alu_busy,
  output logic                            host_err
);

  localparam int WIDX_W = $clog2(P_NWORDS);

  state_t                  state;
  logic [WIDX_W-1:0]       cnt;
  func_t                   func_q;
  logic [2:0]              idx_q;
  logic                    wc;
  logic                    zacc;
  logic                    c_q, z_q, w0_q;
  logic [P_WORD_WIDTH-1:0] w_q [P_NWORDS];
  logic [P_WORD_WIDTH-1:0] rf  [8][P_NWORDS];

  func_t                   op_func;
  logic [WIDX_W-1:0]       widx;
  logic                    last;
  logic [P_WORD_WIDTH-1:0] y;
  logic                    cout;
  logic [2:0]              host_reg;
  logic [WIDX_W-1:0]       host_word;

  assign op_func   = func_t'(alu_op_code[FUNC_MSB:FUNC_LSB]);
  // SHR walks MSW->LSW so the carry enters at the top; with a power-of-2 count ~cnt is the mirror index.
  assign widx      = (func_q == F_SHR) ? ~cnt : cnt;
  assign last      = &cnt;
  assign host_reg  = host_addr[WIDX_W+2:WIDX_W];
  assign host_word = host_addr[WIDX_W-1:0];

  eccop_alu_word #(.P_WORD_WIDTH(P_WORD_WIDTH)) u_word (
    .func (func_q),
    .a    (w_q[widx]),
    .b    (rf[idx_q][widx]),
    .cin  (wc),
    .y    (y),
    .cout (cout)
  );

  // W is rewritten in place word by word; nothing outside can observe it before DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      func_q <= F_LD;
      idx_q  <= '0;
      wc     <= 1'b0;
      zacc   <= 1'b0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      w0_q   <= 1'b0;
      for (int i = 0; i < P_NWORDS; i++) w_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alu_op_req) begin
            func_q <= op_func;
            idx_q  <= alu_op_code[IDX_MSB:IDX_LSB];
            cnt    <= '0;
            wc     <= carry_init(op_func, c_q);
            zacc   <= 1'b0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          w_q[widx] <= y;
          wc        <= cout;
          zacc      <= zacc | (|y);
          cnt       <= cnt + WIDX_W'(1);
          if (last) begin
            state <= S_DONE;
            z_q   <= ~(zacc | (|y));
            w0_q  <= (widx == '0) ? y[0] : w_q[0][0];
            if (func_q inside {F_ADD, F_ADC, F_SUB, F_SHR, F_SHL}) c_q <= cout;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ST commits the whole row at the edge entering DONE, so an aborted ST leaves RF intact.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && last && func_q == F_ST) begin
      for (int i = 0; i < P_NWORDS; i++) rf[idx_q][i] <= w_q[i];
    end
    if (state == S_IDLE && host_we) rf[host_reg][host_word] <= host_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata <= '0;
      host_err   <= 1'b0;
    end else begin
      if (host_re) host_rdata <= rf[host_reg][host_word];
      if (host_we && state != S_IDLE) host_err <= 1'b1;
    end
  end

  assign alu_op_ack      = (state == S_DONE);
  assign alu_busy        = (state != S_IDLE);
  assign alu_flags_carry = c_q;
  assign alu_flags_zero  = z_q;
  assign alu_flags_w0    = w0_q;

endmodule
